// File: rtl/ground_pkg.sv
// Shared constants for the ground bound-check path: default coordinate and
// tag widths, screen extent and the tag value that marks a rejected point.
package ground_pkg;

    // Projected coordinates arrive wide; the pixel writer takes narrow ones.
    localparam int COORD_IN_W  = 18;
    localparam int COORD_OUT_W = 10;
    localparam int TAG_W       = 10;

    // Largest inclusive screen coordinate on either axis.
    localparam int SCREEN_MAX  = 320;

    // Tag value emitted for an out-of-bounds point (all ones at any width).
    localparam int TAG_INVALID = -1;

endpackage : ground_pkg

// File: rtl/ground_range_cmp.sv
// Combinational inclusive signed range check of one coordinate axis.
// The bounds are sign-extended (or truncated) to the coordinate width so
// that the comparison happens entirely at W bits.
module ground_range_cmp #(
    parameter int W  = 18,
    parameter int LO = 0,
    parameter int HI = 320
) (
    input  logic [W-1:0] v,
    output logic         in_range
);

    localparam logic signed [W-1:0] LO_C = W'(LO);
    localparam logic signed [W-1:0] HI_C = W'(HI);

    assign in_range = ($signed(v) >= LO_C) && ($signed(v) <= HI_C);

endmodule : ground_range_cmp

// File: rtl/ground_bound_check_pipe.sv
// Two-stage, back-pressured ground validity checker.
// Stage 1 captures a projected point and its tag; stage 2 holds the result:
// the point narrowed to screen width when every checked axis is in range,
// otherwise the reject pattern (tag -1, coordinates all ones).
// Optional build macro BOUND_STATS_EN adds the rej_count port and a
// saturating counter of rejected points leaving the block.
module ground_bound_check_pipe
    import ground_pkg::*;
#(
    parameter int IN_W    = COORD_IN_W,
    parameter int OUT_W   = COORD_OUT_W,   // 2 <= OUT_W <= IN_W
    parameter int P_W     = TAG_W,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = SCREEN_MAX,
    parameter int Y_MIN   = 0,
    parameter int Y_MAX   = SCREEN_MAX,
    parameter int CHECK_Z = 0,
    parameter int Z_MIN   = 0,
    parameter int Z_MAX   = 511
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P_W-1:0]   in_p,
    input  logic [IN_W-1:0]  in_x,
    input  logic [IN_W-1:0]  in_y,
    input  logic [IN_W-1:0]  in_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_en,
    output logic [P_W-1:0]   out_p,
    output logic [OUT_W-1:0] out_x,
    output logic [OUT_W-1:0] out_y,
    output logic [OUT_W-1:0] out_z
`ifdef BOUND_STATS_EN
    ,
    output logic [15:0]      rej_count
`endif
);

    // Axis 0 = x, 1 = y, 2 = z; the z check only exists when CHECK_Z is set.
    localparam int AXIS_LO [3] = '{X_MIN, Y_MIN, Z_MIN};
    localparam int AXIS_HI [3] = '{X_MAX, Y_MAX, Z_MAX};
    localparam logic [P_W-1:0] TAG_REJ = P_W'(TAG_INVALID);

    logic [IN_W-1:0]  in_c [3];

    logic             s1_valid_q;
    logic             s1_valid_d;
    logic [P_W-1:0]   s1_p_q;
    logic [IN_W-1:0]  s1_c_q [3];

    logic [2:0]       axis_ok;
    logic             in_bounds;
    logic [OUT_W-1:0] narrow_c [3];

    logic             out_valid_q;
    logic             out_valid_d;
    logic             out_en_q;
    logic [P_W-1:0]   out_p_q;
    logic [OUT_W-1:0] out_c_q [3];

    logic             s2_adv;
    logic             s1_adv;
    logic             s2_load;

    assign in_c[0] = in_x;
    assign in_c[1] = in_y;
    assign in_c[2] = in_z;

    // A stage may advance when it is empty or its consumer takes the item
    // this cycle; in_ready follows out_ready combinationally so a full
    // pipeline streams one point per cycle without bubbles.
    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign s2_load  = s2_adv && s1_valid_q;

    // Next-state of the two stage valid flags.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
        end
    end

    // Stage valid flags: the only state a mid-stream reset must clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Stage 1 payload capture on an accepted input; no reset needed because
    // s1_valid_q qualifies it.
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_p_q <= in_p;
            for (int i = 0; i < 3; i++) begin
                s1_c_q[i] <= in_c[i];
            end
        end
    end

    // Per-axis range check and narrowing of the stage 1 point. Narrowing
    // keeps the sign bit and the low OUT_W-1 bits; it never saturates.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_axis
            if (gi < 2 || CHECK_Z != 0) begin : g_cmp
                ground_range_cmp #(
                    .W  (IN_W),
                    .LO (AXIS_LO[gi]),
                    .HI (AXIS_HI[gi])
                ) u_cmp (
                    .v        (s1_c_q[gi]),
                    .in_range (axis_ok[gi])
                );
            end else begin : g_nocmp
                // z passes unconditionally; its upper bits are only narrowed away.
                logic unused_z;
                assign unused_z    = ^s1_c_q[gi];
                assign axis_ok[gi] = 1'b1;
            end
            assign narrow_c[gi] = {s1_c_q[gi][IN_W-1], s1_c_q[gi][OUT_W-2:0]};
        end
    endgenerate

    assign in_bounds = &axis_ok;

    // Stage 2 output registers: load the checked point or the reject
    // pattern; held unchanged while the downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_en_q <= 1'b0;
            out_p_q  <= TAG_REJ;
            for (int i = 0; i < 3; i++) begin
                out_c_q[i] <= '1;
            end
        end else if (s2_load) begin
            out_en_q <= in_bounds;
            out_p_q  <= in_bounds ? s1_p_q : TAG_REJ;
            for (int i = 0; i < 3; i++) begin
                out_c_q[i] <= in_bounds ? narrow_c[i] : '1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_en    = out_en_q;
    assign out_p     = out_p_q;
    assign out_x     = out_c_q[0];
    assign out_y     = out_c_q[1];
    assign out_z     = out_c_q[2];

`ifdef BOUND_STATS_EN
    logic [15:0] rej_count_q;
    logic [15:0] rej_count_d;

    // Count rejected points as they are handed downstream, sticking at full scale.
    always_comb begin
        rej_count_d = rej_count_q;
        if (out_valid_q && out_ready && !out_en_q && rej_count_q != 16'hFFFF) begin
            rej_count_d = rej_count_q + 16'd1;
        end
    end

    // Reject counter register; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rej_count_q <= 16'd0;
        end else begin
            rej_count_q <= rej_count_d;
        end
    end

    assign rej_count = rej_count_q;
`endif

endmodule : ground_bound_check_pipe

// File: doc/ground_bound_check_pipe.md
Name: ground_bound_check_pipe

Overview:
- Parametrised, back-pressured successor to the single-stage ground validity checker in the ray/maze render path.
- Takes a projected point (x, y, z) with a tag p. Checks it against per-axis bounds, then narrows it to screen-coordinate width.
- Sits between the projection/intersection stage and the ground texture/pixel writer.
- Adds a valid/ready handshake, a 2-stage pipeline, optional Z checking and an optional reject counter.

Parameters:
- IN_W, 18, signed width of in_x/in_y/in_z.
- OUT_W, 10, signed width of out_x/out_y/out_z; must be ≥2 and ≤IN_W.
- P_W, 10, signed width of the tag in_p/out_p.
- X_MIN, 0, inclusive lower x bound (signed).
- X_MAX, 320, inclusive upper x bound.
- Y_MIN, 0, inclusive lower y bound.
- Y_MAX, 320, inclusive upper y bound.
- CHECK_Z, 0, 1 = also require Z_MIN ≤ z ≤ Z_MAX.
- Z_MIN, 0, inclusive lower z bound.
- Z_MAX, 511, inclusive upper z bound.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input point valid
- in_ready  out  1  block can accept a point this cycle
- in_p  in  P_W  signed tag (texture/plane id)
- in_x  in  IN_W  signed x
- in_y  in  IN_W  signed y
- in_z  in  IN_W  signed z
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_en  out  1  1 = point in bounds
- out_p  out  P_W  tag, or -1 if rejected
- out_x  out  OUT_W  narrowed x, or all ones if rejected
- out_y  out  OUT_W  narrowed y, or all ones if rejected
- out_z  out  OUT_W  narrowed z, or all ones if rejected
- rej_count  out  16  rejected-point count (only with BOUND_STATS_EN)

Behaviour:
- Reset (async assert, sync deassert taken from rst_n):
  - Both stage valid flags, out_valid and out_en = 0.
  - out_p = -1; out_x/out_y/out_z = all ones; rej_count = 0.
- Stage 1 (S1):
  - Registers the inputs on the handshake in_valid && in_ready.
  - Computes in_bounds = (X_MIN ≤ x ≤ X_MAX) && (Y_MIN ≤ y ≤ Y_MAX) && (!CHECK_Z || Z_MIN ≤ z ≤ Z_MAX).
  - All compares are signed at IN_W; bounds are sign-extended.
- Stage 2 (S2, output registers):
  - In bounds: out_en = 1, out_p = p, out_c = {c[IN_W-1], c[OUT_W-2:0]} for each axis (sign bit kept, low bits truncated; no saturation).
  - Out of bounds: out_en = 0, out_p = -1, out_x/out_y/out_z = all ones.
- Latency: exactly 2 cycles from input handshake to out_valid when out_ready is held high. Throughput: 1 point/cycle.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no bubble at full throughput).
  - S2 loads from S1 when s2_adv && s1_valid. out_valid clears when out_ready is high and S1 is empty.
  - While out_valid && !out_ready, all outputs are held stable and no data is dropped or duplicated.
- Boundaries:
  - Values equal to a bound are valid (320 accepted, 321 rejected, -1 rejected).
  - in_valid with in_ready low: input ignored; the source must hold it.
  - Payload registers need no reset beyond the values stated above; valid flags do.
  - Reset mid-stream discards both stages; no output is produced for discarded points.

Optional Feature:
- BOUND_STATS_EN defined:
  - rej_count increments by 1 on each output handshake with out_en = 0.
  - It saturates at 16'hFFFF and clears only on reset.
- BOUND_STATS_EN undefined: the rej_count port and counter logic are absent.

Decomposition:
- Shared package ground_pkg:
  - Default widths: COORD_IN_W = 18, COORD_OUT_W = 10, TAG_W = 10.
  - Screen bounds: SCREEN_MAX = 320.
  - Reject constant TAG_INVALID = -1.
- Sub-module ground_range_cmp: combinational per-axis signed inclusive range compare, parametrised by width and bounds; instantiated 2 or 3 times.

Test Plan:
- Default params, out_ready = 1, point (x=100, y=200, z=5, p=3) → 2 cycles later: out_valid = 1, out_en = 1, out_x = 100, out_y = 200, out_z = 5, out_p = 3.
- Edge sweep x ∈ {-1, 0, 320, 321}, y = 10 → out_en = 0, 1, 1, 0. Rejected points give out_p = -1 and out_x = 10'h3FF.
- Back-to-back 8 points with out_ready toggling 1,0,0,1,… → all 8 emerge in order, no loss or duplication, outputs stable while stalled, in_ready = 0 only when both stages are full and stalled.
- CHECK_Z = 1, Z_MAX = 100, point (x=10, y=10, z=101) → out_en = 0. With z = 100 → out_en = 1.
- rst_n pulsed low while 2 points are in flight → out_valid drops immediately, outputs at reset values, nothing emitted after release.
- With BOUND_STATS_EN: 5 rejected + 3 accepted points → rej_count = 5. Preloaded to 16'hFFFF, one more reject → stays 16'hFFFF.
